// File: rtl/rv_trace_tx.sv
// Retirement-trace transmitter: buffers one record per retired instruction and
// serializes each as a 9/13/17/21-byte little-endian packet over a byte stream.
module rv_trace_tx #(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int DROP_CNT_BITS    = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_wb_valid,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc,
    input  logic [31:0]                 i_instr,
    input  logic                        i_reg_write,
    input  logic [31:0]                 i_rd_data,
    input  logic                        i_mem_read,
    input  logic                        i_mem_write,
    input  logic [31:0]                 i_mem_addr,
    input  logic [31:0]                 i_mem_data,
    output logic [7:0]                  o_tx_data,
    output logic                        o_tx_valid,
    input  logic                        i_tx_ready,
    output logic [DROP_CNT_BITS-1:0]    o_drop_cnt,
    output logic                        o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic        ovf;
        logic        mw;
        logic        mr;
        logic        rw;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd;
        logic [31:0] maddr;
        logic [31:0] mdata;
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PC,
        S_INSTR,
        S_RD,
        S_MADDR,
        S_MDATA
    } state_t;

    rec_t                     r_mem [FIFO_DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [AW:0]              r_count;
    logic                     r_ovf_pend;
    logic [DROP_CNT_BITS-1:0] r_drop_cnt;
    state_t                   r_state;
    logic [1:0]               r_idx;
    logic [7:0]               r_tx_data;
    logic                     r_tx_valid;

    state_t     w_state_nxt;
    logic [1:0] w_idx_nxt;
    logic [7:0] w_tx_data_nxt;
    logic       w_tx_valid_nxt;
    logic       w_full;
    logic       w_push;
    logic       w_drop;
    logic       w_pop;
    logic       w_hs;
    logic       w_last;
    logic       w_mem_any;
    rec_t       w_head;
    rec_t       w_wr_rec;
    logic [7:0] w_next_hdr;

    function automatic logic [7:0] hdr_byte(input rec_t r);
        return {1'b1, 3'b000, r.mw, r.mr, r.rw, r.ovf};
    endfunction

    function automatic logic [7:0] field_byte(input logic [31:0] f, input logic [1:0] idx);
        return f[8*idx +: 8];
    endfunction

    function automatic logic [7:0] sel_byte(input rec_t r, input state_t st, input logic [1:0] idx);
        logic [7:0] b;
        case (st)
            S_HDR:   b = hdr_byte(r);
            S_PC:    b = field_byte(r.pc, idx);
            S_INSTR: b = field_byte(r.instr, idx);
            S_RD:    b = field_byte(r.rd, idx);
            S_MADDR: b = field_byte(r.maddr, idx);
            S_MDATA: b = field_byte(r.mdata, idx);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_push = i_wb_valid & ~w_full;
    assign w_drop = i_wb_valid & w_full;

    // A store that also flags a read is recorded as a pure store.
    assign w_wr_rec = '{
        ovf:   r_ovf_pend,
        mw:    i_mem_write,
        mr:    i_mem_read & ~i_mem_write,
        rw:    i_reg_write,
        pc:    32'(i_pc),
        instr: i_instr,
        rd:    i_rd_data,
        maddr: i_mem_addr,
        mdata: i_mem_data
    };

    assign w_head     = r_mem[r_rd_ptr];
    assign w_next_hdr = hdr_byte(r_mem[r_rd_ptr + AW'(1)]);
    assign w_mem_any  = w_head.mr | w_head.mw;
    assign w_hs       = r_tx_valid & i_tx_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_pop          = 1'b0;
        w_last         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt    = S_HDR;
                    w_idx_nxt      = 2'd0;
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = hdr_byte(w_head);
                end
            end
            default: begin
                if (w_hs) begin
                    if (r_state == S_HDR || r_idx == 2'd3) begin
                        w_idx_nxt = 2'd0;
                        case (r_state)
                            S_HDR:   w_state_nxt = S_PC;
                            S_PC:    w_state_nxt = S_INSTR;
                            S_INSTR: begin
                                if (w_head.rw)      w_state_nxt = S_RD;
                                else if (w_mem_any) w_state_nxt = S_MADDR;
                                else                w_last = 1'b1;
                            end
                            S_RD: begin
                                if (w_mem_any) w_state_nxt = S_MADDR;
                                else           w_last = 1'b1;
                            end
                            S_MADDR: w_state_nxt = S_MDATA;
                            default: w_last = 1'b1;
                        endcase
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                    end

                    if (w_last) begin
                        w_pop = 1'b1;
                        // Only records already stored count; a same-cycle push waits for IDLE.
                        if (r_count > (AW+1)'(1)) begin
                            w_state_nxt   = S_HDR;
                            w_tx_data_nxt = w_next_hdr;
                        end else begin
                            w_state_nxt    = S_IDLE;
                            w_tx_valid_nxt = 1'b0;
                            w_tx_data_nxt  = 8'h00;
                        end
                    end else begin
                        w_tx_data_nxt = sel_byte(w_head, w_state_nxt, w_idx_nxt);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf_pend <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_drop)      r_ovf_pend <= 1'b1;
            else if (w_push) r_ovf_pend <= 1'b0;
            if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_BITS'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_rec;
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_drop_cnt = r_drop_cnt;
    assign o_busy     = (r_count != '0) | (r_state != S_IDLE);

endmodule
